// File: rtl/mem_pkg.sv
// Shared definitions for the sub-word data memory: access-size codes, FSM states
// and the alignment check shared by the datapath.
package mem_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Illegal size code or a half/word access not on its natural boundary
    function automatic logic align_err(input logic [1:0] size, input logic [1:0] lane);
        logic err;
        case (size)
            SIZE_BYTE: err = 1'b0;
            SIZE_HALF: err = lane[0];
            SIZE_WORD: err = |lane;
            default:   err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/lane_align.sv
// Combinational lane steering: store byte enables and data replication, load lane
// extraction with sign or zero extension.
module lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection for loads and size-dependent enables/replication
    always_comb begin
        be     = 4'b0000;
        wword  = 32'd0;
        rdata  = 32'd0;
        byte_s = 8'd0;
        half_s = 16'd0;
        case (lane)
            2'd0:    byte_s = rword[7:0];
            2'd1:    byte_s = rword[15:8];
            2'd2:    byte_s = rword[23:16];
            default: byte_s = rword[31:24];
        endcase
        if (lane[1]) begin
            half_s = rword[31:16];
        end else begin
            half_s = rword[15:0];
        end
        case (size)
            SIZE_BYTE: begin
                be    = 4'b0001 << lane;
                wword = {4{wdata[7:0]}};
                rdata = uns ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
            end
            SIZE_HALF: begin
                be    = 4'b0011 << lane;
                wword = {2{wdata[15:0]}};
                rdata = uns ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
            end
            SIZE_WORD: begin
                be    = 4'b1111;
                wword = wdata;
                rdata = rword;
            end
            default: begin
                be    = 4'b0000;
                wword = 32'd0;
                rdata = 32'd0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_subword.sv
// Data memory with byte/half/word loads and stores, one-cycle registered response
// and a post-reset sweep that zero-fills the array before requests are accepted.
module data_mem_subword
    import mem_pkg::*;
#(
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 32,
    parameter bit CLEAR_EN   = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_uns,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error
);

    localparam int     IDX_W    = $clog2(DEPTH);
    localparam state_t ST_RESET = CLEAR_EN ? ST_CLEAR : ST_READY;

    state_t                  state_r, state_next_s;
    logic [IDX_W-1:0]        clr_ptr_r, clr_ptr_next_s;
    logic                    req_ready_r;
    logic                    rsp_valid_r, rsp_error_r;
    logic [31:0]             rsp_rdata_r;
    logic [31:0]             mem_r [DEPTH];

    logic                    accept_s, err_s;
    logic [IDX_W-1:0]        idx_s;
    logic [ADDR_WIDTH-1:0]   addr_hi_s;
    logic [3:0]              be_s;
    logic [31:0]             wword_s, rword_s, rdata_s;

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_error = rsp_error_r;

    assign accept_s  = req_valid & req_ready_r;
    assign idx_s     = req_addr[IDX_W+1:2];
    // Any bit above the array span means the byte address is at or past 4*DEPTH
    assign addr_hi_s = req_addr >> (IDX_W + 2);
    assign err_s     = align_err(req_size, req_addr[1:0]) | (|addr_hi_s);
    assign rword_s   = mem_r[idx_s];

    lane_align u_lane_align (
        .size  (req_size),
        .lane  (req_addr[1:0]),
        .uns   (req_uns),
        .wdata (req_wdata),
        .rword (rword_s),
        .be    (be_s),
        .wword (wword_s),
        .rdata (rdata_s)
    );

    // FSM state, clear pointer and ready flag registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= ST_RESET;
            clr_ptr_r   <= '0;
            req_ready_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            clr_ptr_r   <= clr_ptr_next_s;
            req_ready_r <= (state_next_s == ST_READY);
        end
    end

    // Next-state logic: sweep every word once, then serve requests indefinitely
    always_comb begin
        state_next_s   = state_r;
        clr_ptr_next_s = clr_ptr_r;
        case (state_r)
            ST_CLEAR: begin
                clr_ptr_next_s = clr_ptr_r + {{(IDX_W-1){1'b0}}, 1'b1};
                if (clr_ptr_r == IDX_W'(DEPTH - 1)) begin
                    state_next_s = ST_READY;
                end else begin
                    state_next_s = ST_CLEAR;
                end
            end
            ST_READY: state_next_s = ST_READY;
            default: begin
                state_next_s   = ST_RESET;
                clr_ptr_next_s = '0;
            end
        endcase
    end

    // Storage: zero one word per clear cycle, otherwise byte-lane writes of clean stores
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem_r[clr_ptr_r] <= 32'd0;
        end else if (accept_s && req_we && !err_s) begin
            for (int b = 0; b < 4; b++) begin
                if (be_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= wword_s[8*b +: 8];
                end
            end
        end
    end

    // Response registers; data and error hold between pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'd0;
            rsp_error_r <= 1'b0;
        end else begin
            rsp_valid_r <= accept_s;
            if (accept_s) begin
                rsp_error_r <= err_s;
                rsp_rdata_r <= (req_we || err_s) ? 32'd0 : rdata_s;
            end
        end
    end

endmodule
